// File: rtl/route_pkg.sv
// Shared types for the route sequencer and its token FIFO.
// Channel count and destination/credit-vector typedefs.
package route_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] dest_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/route_fifo.sv
// In-order token buffer of destination channels.
// Push is ignored when full, pop is ignored when empty.
module route_fifo
    import route_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  dest_t din,
    output dest_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    dest_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CNTW-1:0] count;
    logic do_push;
    logic do_pop;

    assign full = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10: count <= count + CNTW'(1);
                2'b01: count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/route_sequencer.sv
// Buffers destination tokens and issues them in order as i/s,
// gated by per-channel credits returned by the downstream sinks.
module route_sequencer
    import route_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CREDITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_dest,
    input  logic [3:0] credit_ret,
    output logic       i,
    output logic [1:0] s,
    output logic       busy
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [CW-1:0] credit [NUM_CH];
    logic [CW-1:0] credit_nxt [NUM_CH];
    ch_vec_t issue_vec;
    dest_t head;
    logic full;
    logic empty;
    logic issue;
    logic push;

    assign in_ready = !full;
    assign push = in_valid && !full;
    assign issue = !empty && (credit[head] != '0);
    assign busy = !empty || i;

    route_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (issue),
        .din  (in_dest),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    always_comb begin
        issue_vec = '0;
        if (issue) begin
            issue_vec[head] = 1'b1;
        end
    end

    // Return and issue together cancel; returns saturate at CMAX.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            credit_nxt[k] = credit[k];
            unique case (1'b1)
                (credit_ret[k] && !issue_vec[k] && credit[k] != CMAX):
                    credit_nxt[k] = credit[k] + CW'(1);
                (issue_vec[k] && !credit_ret[k]):
                    credit_nxt[k] = credit[k] - CW'(1);
                default: credit_nxt[k] = credit[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                credit[k] <= CMAX;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                credit[k] <= credit_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= 1'b0;
            s <= '0;
        end else begin
            i <= issue;
            if (issue) begin
                s <= head;
            end
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// Directed and random stimulus against a queue-based model
// of the route sequencer.
module tb_route_sequencer;

    localparam int DEPTH = 4;
    localparam int CREDITS = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_dest;
    logic [3:0] credit_ret;
    logic       i;
    logic [1:0] s;
    logic       busy;

    int vectors;
    int miscompares;

    int q[$];
    int cred[4];
    logic exp_i;
    logic [1:0] exp_s;

    route_sequencer #(
        .DEPTH(DEPTH),
        .CREDITS(CREDITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .credit_ret(credit_ret),
        .i         (i),
        .s         (s),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic e_busy;
        logic e_ready;
        e_busy = (q.size() > 0) || exp_i;
        e_ready = (q.size() < DEPTH);
        vectors++;
        assert (i === exp_i) else begin
            miscompares++;
            $error("FAIL %s.i got %0b want %0b", tag, i, exp_i);
        end
        vectors++;
        assert (s === exp_s) else begin
            miscompares++;
            $error("FAIL %s.s got %0d want %0d", tag, s, exp_s);
        end
        vectors++;
        assert (in_ready === e_ready) else begin
            miscompares++;
            $error("FAIL %s.in_ready got %0b want %0b", tag, in_ready, e_ready);
        end
        vectors++;
        assert (busy === e_busy) else begin
            miscompares++;
            $error("FAIL %s.busy got %0b want %0b", tag, busy, e_busy);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 4; k++) cred[k] = CREDITS;
        exp_i = 1'b0;
        exp_s = 2'd0;
    endtask

    // Called at a negedge; applies one clock edge and checks after it.
    task automatic cycle(input string tag, input logic v,
                         input logic [1:0] d, input logic [3:0] r);
        bit acc;
        bit iss;
        int hd;
        int c;
        in_valid = v;
        in_dest = d;
        credit_ret = r;
        acc = v && (q.size() < DEPTH);
        iss = (q.size() > 0) && (cred[q[0]] > 0);
        hd = iss ? q[0] : -1;
        if (iss) begin
            void'(q.pop_front());
            exp_i = 1'b1;
            exp_s = 2'(hd);
        end else begin
            exp_i = 1'b0;
        end
        if (acc) q.push_back(int'(d));
        for (int k = 0; k < 4; k++) begin
            c = cred[k] + int'(r[k]) - ((hd == k) ? 1 : 0);
            cred[k] = (c > CREDITS) ? CREDITS : c;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_dest = 2'd0;
        credit_ret = 4'd0;
        check(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_dest = 2'd0;
        credit_ret = 4'd0;
        model_reset();
        #1;
        check(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_rel"});
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_dest = 2'd0;
        credit_ret = 4'd0;
        model_reset();
        #2;
        @(negedge clk);
        do_reset("rst");

        idle("idle", 2);
        cycle("p2", 1'b1, 2'd2, 4'd0);
        idle("p2_out", 3);

        do_reset("rst_b2b");
        cycle("b2b", 1'b1, 2'd0, 4'd0);
        cycle("b2b", 1'b1, 2'd1, 4'd0);
        cycle("b2b", 1'b1, 2'd2, 4'd0);
        cycle("b2b", 1'b1, 2'd3, 4'd0);
        cycle("b2b", 1'b1, 2'd0, 4'd0);
        idle("b2b_out", 3);
        cycle("b2b_c0", 1'b1, 2'd0, 4'd0);
        idle("b2b_c0", 3);

        do_reset("rst_stall");
        cycle("stall", 1'b1, 2'd1, 4'd0);
        cycle("stall", 1'b1, 2'd1, 4'd0);
        cycle("stall", 1'b1, 2'd1, 4'd0);
        cycle("stall", 1'b1, 2'd3, 4'd0);
        idle("stall_hold", 3);
        cycle("stall_ret", 1'b0, 2'd0, 4'b0010);
        idle("stall_go", 4);

        do_reset("rst_full");
        for (int k = 0; k < 8; k++) cycle("drain", 1'b1, 2'(k / 2), 4'd0);
        idle("drain", 2);
        cycle("fill", 1'b1, 2'd0, 4'd0);
        cycle("fill", 1'b1, 2'd1, 4'd0);
        cycle("fill", 1'b1, 2'd2, 4'd0);
        cycle("fill", 1'b1, 2'd3, 4'd0);
        cycle("fill5", 1'b1, 2'd2, 4'd0);
        idle("full_hold", 2);
        cycle("full_ret", 1'b0, 2'd0, 4'b0001);
        cycle("full_pop", 1'b0, 2'd0, 4'd0);

        do_reset("rst_mid");
        idle("post_rst", 3);
        cycle("post_rst_p", 1'b1, 2'd3, 4'd0);
        idle("post_rst_p", 2);

        do_reset("rst_same");
        cycle("same", 1'b1, 2'd0, 4'd0);
        cycle("same", 1'b1, 2'd0, 4'd0);
        cycle("same_ret", 1'b1, 2'd0, 4'b0001);
        cycle("same", 1'b1, 2'd0, 4'd0);
        idle("same_out", 3);

        do_reset("rst_sat");
        cycle("sat", 1'b0, 2'd0, 4'b1111);
        cycle("sat", 1'b0, 2'd0, 4'b1111);
        for (int k = 0; k < 3; k++) cycle("sat_p", 1'b1, 2'd2, 4'd0);
        idle("sat_out", 4);

        do_reset("rst_rand");
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) == 0);
            cycle("rand", 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), r);
            if (n == 300) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
